hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller sitting between the decode stage and EX. It keeps a three-slot scoreboard of in-flight register writers (EX, MEM, WB), decides each cycle whether the decoded instruction issues, stalls or is flushed, and drives the operand forwarding selects for the EX-stage ALU input muxes. It replaces per-stage ad-hoc load tracking with one central sequencer for the whole datapath.

## Interface
Parameters:
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode holds a real instruction; 0 means bubble.
- id_rs  in  REG_AW  first source register.
- id_rt  in  REG_AW  second source register.
- id_rs_used  in  1  instruction reads id_rs.
- id_rt_used  in  1  instruction reads id_rt.
- id_wr_en  in  1  instruction writes a register.
- id_rd  in  REG_AW  destination register.
- id_is_load  in  1  instruction is a memory load (LDW).
- br_taken  in  1  EX resolved a taken branch or jump this cycle.
- issue  out  1  decode instruction enters EX at the next edge.
- stall  out  1  hold PC and the IF/ID register.
- flush  out  1  squash IF/ID; a bubble enters EX.
- fwd_rs  out  2  rs source: 0 = regfile, 1 = EX result, 2 = MEM result, 3 = WB result.
- fwd_rt  out  2  rt source, same encoding.

## Operation
- Scoreboard slots s1 (EX), s2 (MEM), s3 (WB). Each slot holds {valid, rd, is_load}.
- At each edge: s3 <= s2, s2 <= s1. s1 <= {id_wr_en && id_rd != 0, id_rd, id_is_load} if issue, otherwise the bubble {0, 0, 0}.
- match(sN, r, used) = used && r != 0 && sN.valid && sN.rd == r. Register 0 never matches.
- Priority: flush > stall > issue.
- flush = br_taken. When flush is 1: stall = 0, issue = 0, fwd = 0.
- hazard (forwarding build):
  - A load in s1 matches either used source.
  - Load-use is the only stall cause.
- hazard (no-forward build):
  - Any of s1, s2 or s3 matches either used source.
- stall = id_valid && hazard && !flush.
- issue = id_valid && !hazard && !flush.
- Forward select per source, youngest matching slot wins:
  - s1 gives 1 (s1 never matches as a load when issue = 1).
  - Else s2 gives 2.
  - Else s3 gives 3.
  - Else 0.
- fwd outputs are meaningful only when issue = 1; otherwise they are 0.

## Timing
- issue, stall, flush and fwd_* are combinational from the scoreboard and the current inputs, valid within the same cycle.
- Scoreboard latency: an issued writer is visible in s1 from the next cycle and retires 3 cycles after issue.
- Reset:
  - While rst = 1, all outputs are forced to 0 regardless of the other inputs.
  - At the edge with rst = 1, all slots are cleared.
  - Reset in mid-stall drops the stalled instruction's hazard state; the stall deasserts immediately.
- Load-use stall (forwarding build): exactly 1 cycle. The load then sits in s2 and the consumer issues with fwd = 2.
- No-forward build: the consumer of an immediately preceding writer stalls 3 cycles and issues on the 4th with fwd = 0. The regfile is write-before-read in WB.
- br_taken with a simultaneous hazard: flush wins, and the wrong-path instruction is discarded without stalling.
- Both sources matching different slots: each source is resolved independently.
- Both sources matching the same slot: both selects carry the same code.

## Configuration
- PIPE_FWD_EN defined: forwarding build.
  - Only load-use hazards stall.
  - fwd_rs and fwd_rt are driven as above.
- PIPE_FWD_EN undefined: interlock-only build.
  - Any in-flight matching writer stalls.
  - fwd_rs and fwd_rt are tied to 0.
  - The port list is unchanged.

## Test plan
- Reset: rst = 1 with id_valid = 1, id_rs = 3, and s1 preloaded with writer r3 → issue = stall = flush = 0 and fwd = 0. After release, a consumer of r3 issues with fwd_rs = 0.
- ALU chain (PIPE_FWD_EN): "add r3" issues at cycle 0.
  - Cycle 1: consumer with rs = 3 → issue = 1, fwd_rs = 1.
  - Cycle 2: consumer with rt = 3 → fwd_rt = 2.
  - Cycle 3: consumer with rs = 3 → fwd_rs = 3.
  - Cycle 4: consumer with rs = 3 → fwd_rs = 0.
- Load-use (PIPE_FWD_EN): LDW r5 issues, then a consumer with rt = 5 → stall = 1 and issue = 0 for 1 cycle, then issue = 1 with fwd_rt = 2.
- Register 0: a writer with rd = 0 (load or ALU), followed by a consumer with rs = rt = 0 → no stall, fwd = 0, and s1.valid = 0.
- Branch: a load-use hazard present while br_taken = 1 → flush = 1, stall = 0, issue = 0. On the next cycle s1 is a bubble.
- Interlock build (PIPE_FWD_EN undefined): "add r3", then a consumer with rs = 3 → stall = 1 for 3 cycles, issue = 1 on the 4th cycle with fwd_rs = 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the decode-side request and the hazard controller's verdict so the
//   controller and its pipeline neighbours share one connection point.
//
//   Decode -> controller : id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
//                          id_wr_en, id_rd, id_is_load, br_taken
//   Controller -> pipe   : issue, stall, flush, fwd_rs, fwd_rt
//
//   master modport : the pipeline side that presents the decoded instruction
//   slave modport  : the hazard controller itself
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_rd;
  logic              id_is_load;
  logic              br_taken;
  logic              issue;
  logic              stall;
  logic              flush;
  logic [1:0]        fwd_rs;
  logic [1:0]        fwd_rt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_wr_en, id_rd, id_is_load, br_taken,
    input  issue, stall, flush, fwd_rs, fwd_rt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_wr_en, id_rd, id_is_load, br_taken,
    output issue, stall, flush, fwd_rs, fwd_rt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Central hazard sequencer between decode and EX. Tracks the register
//   writers currently in EX, MEM and WB (slots s1, s2, s3) and decides each
//   cycle whether the decoded instruction issues, stalls or is flushed. In the
//   forwarding build it also drives the EX operand forwarding selects.
//
//   Ports:
//     clk  : pipeline clock, all state moves on the rising edge
//     rst  : synchronous active-high reset; forces every output low and
//            empties the scoreboard at the edge
//     bus  : hazard_ctrl_if.slave carrying the decoded instruction fields,
//            br_taken, and the issue/stall/flush/fwd_rs/fwd_rt results
//
//   Build option:
//     PIPE_FWD_EN defined   -> forwarding build, only load-use stalls
//     PIPE_FWD_EN undefined -> interlock-only build, any in-flight matching
//                              writer stalls and both forward selects are 0
module hazard_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  // Index 0 = s1 (EX), 1 = s2 (MEM), 2 = s3 (WB)
  logic [2:0]        slotValid_q;
  logic [REG_AW-1:0] slotRd_q [3];
  logic              s1Valid_d;
  logic [REG_AW-1:0] s1Rd_d;

  logic [2:0] matchRs;
  logic [2:0] matchRt;
  logic       hazard;
  logic       issueW;
  logic       stallW;
  logic       flushW;

`ifdef PIPE_FWD_EN
  // Only the EX-stage load flag is ever consulted: once a load reaches MEM its
  // data can be forwarded, so older load flags carry no information.
  logic s1Load_q;
  logic s1Load_d;

  // Youngest matching slot wins.
  function automatic logic [1:0] pickSrc(input logic [2:0] m);
    if (m[0])      return 2'd1;
    else if (m[1]) return 2'd2;
    else if (m[2]) return 2'd3;
    else           return 2'd0;
  endfunction
`endif

  always_comb begin
    matchRs = '0;
    matchRt = '0;
    for (int n = 0; n < 3; n++) begin
      matchRs[n] = bus.id_rs_used && (bus.id_rs != '0) &&
                   slotValid_q[n] && (slotRd_q[n] == bus.id_rs);
      matchRt[n] = bus.id_rt_used && (bus.id_rt != '0) &&
                   slotValid_q[n] && (slotRd_q[n] == bus.id_rt);
    end
  end

`ifdef PIPE_FWD_EN
  assign hazard = s1Load_q && (matchRs[0] || matchRt[0]);
`else
  assign hazard = (|matchRs) || (|matchRt);
`endif

  // Reset masks everything; a taken branch overrides any hazard so the
  // wrong-path instruction is dropped rather than held.
  assign flushW = !rst && bus.br_taken;
  assign issueW = !rst && bus.id_valid && !hazard && !bus.br_taken;
  assign stallW = !rst && bus.id_valid &&  hazard && !bus.br_taken;

  assign bus.issue = issueW;
  assign bus.stall = stallW;
  assign bus.flush = flushW;

`ifdef PIPE_FWD_EN
  assign bus.fwd_rs = issueW ? pickSrc(matchRs) : 2'd0;
  assign bus.fwd_rt = issueW ? pickSrc(matchRt) : 2'd0;
`else
  logic unusedLoad;
  assign unusedLoad = bus.id_is_load;
  assign bus.fwd_rs = 2'd0;
  assign bus.fwd_rt = 2'd0;
`endif

  // A stalled or flushed cycle pushes a bubble into EX. Writes to r0 are
  // recorded as invalid so they can never create a dependency.
  always_comb begin
    s1Valid_d = 1'b0;
    s1Rd_d    = '0;
    if (issueW) begin
      s1Valid_d = bus.id_wr_en && (bus.id_rd != '0);
      s1Rd_d    = bus.id_rd;
    end
  end

`ifdef PIPE_FWD_EN
  always_comb begin
    s1Load_d = 1'b0;
    if (issueW) begin
      s1Load_d = bus.id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Load_q <= 1'b0;
    end else begin
      s1Load_q <= s1Load_d;
    end
  end
`endif

  // Scoreboard shift: EX -> MEM -> WB every cycle, new entry into EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      slotValid_q <= '0;
      for (int n = 0; n < 3; n++) begin
        slotRd_q[n] <= '0;
      end
    end else begin
      slotValid_q <= {slotValid_q[1:0], s1Valid_d};
      slotRd_q[2] <= slotRd_q[1];
      slotRd_q[1] <= slotRd_q[0];
      slotRd_q[0] <= s1Rd_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Drives hazard_ctrl through directed scenarios and a randomized run. The
//   reference model keeps a queue of the writers issued in the last three
//   cycles (front = most recent) and derives the verdict from dependency age.
//   Result vectors are packed as {issue, stall, flush, fwd_rs, fwd_rt}.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5)) bus ();

  hazard_ctrl #(.REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       ld;
  } writer_t;

  writer_t    inflight[$];
  int         checks = 0;
  int         errors = 0;
  logic [6:0] expVec;
  logic [6:0] obsVec;

  function automatic logic [6:0] pk(input bit i, input bit s, input bit f,
                                    input int a, input int b);
    return {i, s, f, 2'(a), 2'(b)};
  endfunction

  // How many cycles ago the most recent in-flight writer of r was issued
  // (1..3), or 0 if nothing in flight produces r.
  function automatic int ageOf(input bit [4:0] r, input bit used);
    int age = 0;
    if (!used || r == 5'd0) return 0;
    for (int k = inflight.size() - 1; k >= 0; k--) begin
      if (inflight[k].v && inflight[k].rd == r) age = k + 1;
    end
    return age;
  endfunction

  function automatic logic [6:0] modelEval();
    int aRs;
    int aRt;
    bit haz;
    bit iss;
    bit stl;
    bit fl;
    int fRs;
    int fRt;
    if (rst) return 7'd0;
    aRs = ageOf(bus.id_rs, bus.id_rs_used);
    aRt = ageOf(bus.id_rt, bus.id_rt_used);
`ifdef PIPE_FWD_EN
    // Only a load still in EX cannot supply its data in time.
    haz = ((aRs == 1) || (aRt == 1)) && inflight.size() > 0 && inflight[0].ld;
`else
    haz = (aRs != 0) || (aRt != 0);
`endif
    fl  = bus.br_taken;
    iss = bus.id_valid && !haz && !fl;
    stl = bus.id_valid && haz && !fl;
`ifdef PIPE_FWD_EN
    fRs = iss ? aRs : 0;
    fRt = iss ? aRt : 0;
`else
    fRs = 0;
    fRt = 0;
`endif
    return pk(iss, stl, fl, fRs, fRt);
  endfunction

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input bit v, input bit [4:0] rs, input bit rsU,
                               input bit [4:0] rt, input bit rtU, input bit we,
                               input bit [4:0] rd, input bit ld, input bit br,
                               input bit r);
    @(negedge clk);
    rst            = r;
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rs_used = rsU;
    bus.id_rt      = rt;
    bus.id_rt_used = rtU;
    bus.id_wr_en   = we;
    bus.id_rd      = rd;
    bus.id_is_load = ld;
    bus.br_taken   = br;
    #1;
    expVec = modelEval();
    obsVec = {bus.issue, bus.stall, bus.flush, bus.fwd_rs, bus.fwd_rt};
  endtask

  // Advance one clock and age the model's in-flight writer list.
  task automatic tick();
    logic [6:0] e;
    writer_t    w;
    e = modelEval();
    @(posedge clk);
    if (rst) begin
      inflight.delete();
    end else begin
      if (e[6]) w = '{bus.id_wr_en && bus.id_rd != 5'd0, bus.id_rd, bus.id_is_load};
      else      w = '{1'b0, 5'd0, 1'b0};
      inflight.push_front(w);
      if (inflight.size() > 3) void'(inflight.pop_back());
    end
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_reset();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    checks++;
    if (obsVec !== pk(1, 0, 0, 0, 0)) begin
      errors++;
      $display("[TB] FAIL reset_preload got=%b want=%b", obsVec, pk(1, 0, 0, 0, 0));
    end
    tick();
    applyStimulus(1, 3, 1, 3, 1, 0, 0, 0, 1, 1);
    checks++;
    if (obsVec !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b want=%b", obsVec, 7'd0);
    end
    tick();
    applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obsVec !== pk(1, 0, 0, 0, 0)) begin
      errors++;
      $display("[TB] FAIL reset_release got=%b want=%b", obsVec, pk(1, 0, 0, 0, 0));
    end
    tick();
  endtask

  task automatic test_alu_chain();
    logic [6:0] want [4];
    bit         useRt;
`ifdef PIPE_FWD_EN
    want = '{pk(1, 0, 0, 1, 0), pk(1, 0, 0, 0, 2), pk(1, 0, 0, 3, 0), pk(1, 0, 0, 0, 0)};
`else
    want = '{pk(0, 1, 0, 0, 0), pk(0, 1, 0, 0, 0), pk(0, 1, 0, 0, 0), pk(1, 0, 0, 0, 0)};
`endif
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
`ifdef PIPE_FWD_EN
      useRt = (i == 1);
`else
      useRt = 1'b0;
`endif
      applyStimulus(1, 3, !useRt, 3, useRt, 0, 0, 0, 0, 0);
      checks++;
      if (obsVec !== want[i]) begin
        errors++;
        $display("[TB] FAIL alu_chain_c%0d got=%b want=%b", i + 1, obsVec, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [6:0] want[$];
`ifdef PIPE_FWD_EN
    want = '{pk(0, 1, 0, 0, 0), pk(1, 0, 0, 0, 2)};
`else
    want = '{pk(0, 1, 0, 0, 0), pk(0, 1, 0, 0, 0), pk(0, 1, 0, 0, 0), pk(1, 0, 0, 0, 0)};
`endif
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    tick();
    foreach (want[i]) begin
      applyStimulus(1, 0, 0, 5, 1, 1, 7, 0, 0, 0);
      checks++;
      if (obsVec !== want[i]) begin
        errors++;
        $display("[TB] FAIL load_use_c%0d got=%b want=%b", i + 1, obsVec, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_reg_zero();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    tick();
    checks++;
    if (dut.slotValid_q[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reg_zero_s1valid got=%b want=0", dut.slotValid_q[0]);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 1, 0, 1, (i == 0), 0, 0, 0, 0);
      checks++;
      if (obsVec !== pk(1, 0, 0, 0, 0)) begin
        errors++;
        $display("[TB] FAIL reg_zero_c%0d got=%b want=%b", i + 1, obsVec, pk(1, 0, 0, 0, 0));
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [6:0] want[$];
`ifdef PIPE_FWD_EN
    want = '{pk(1, 0, 0, 0, 2)};
`else
    want = '{pk(0, 1, 0, 0, 0), pk(0, 1, 0, 0, 0), pk(1, 0, 0, 0, 0)};
`endif
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 5, 1, 0, 0, 0, 1, 0);
    checks++;
    if (obsVec !== pk(0, 0, 1, 0, 0)) begin
      errors++;
      $display("[TB] FAIL branch_flush got=%b want=%b", obsVec, pk(0, 0, 1, 0, 0));
    end
    tick();
    foreach (want[i]) begin
      applyStimulus(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
      checks++;
      if (obsVec !== want[i]) begin
        errors++;
        $display("[TB] FAIL branch_after_c%0d got=%b want=%b", i + 1, obsVec, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_both_sources();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 3, 1, 4, 1, 0, 0, 0, 0, 0);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL both_diff_c%0d got=%b want=%b", i, obsVec, expVec);
      end
      tick();
    end
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 6, 1, 6, 1, 0, 0, 0, 0, 0);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL both_same_c%0d got=%b want=%b", i, obsVec, expVec);
      end
      tick();
    end
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 31) == 0);
      checks++;
      if (obsVec !== expVec) begin
        errors++;
        $display("[TB] FAIL random_c%0d got=%b want=%b", i, obsVec, expVec);
      end
      tick();
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.id_valid   = 1'b0;
    bus.id_rs      = '0;
    bus.id_rt      = '0;
    bus.id_rs_used = 1'b0;
    bus.id_rt_used = 1'b0;
    bus.id_wr_en   = 1'b0;
    bus.id_rd      = '0;
    bus.id_is_load = 1'b0;
    bus.br_taken   = 1'b0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_reg_zero();
    test_branch();
    test_both_sources();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
